adder_32bit_seq: RTL and testbench
==================================

ADDER_32BIT_SEQ -- requirements
Module: adder_32bit_seq

Interface
REQ-001 SHALL have parameter: SLICE_W, 8, adder slice width per cycle in bits; legal values 1, 2, 4, 8, 16, 32; N = 32/SLICE_W.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands.
REQ-006 SHALL have port: a  input  32  augend.
REQ-007 SHALL have port: b  input  32  addend.
REQ-008 SHALL have port: cin  input  1  carry into bit 0.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: result  output  32  a + b + cin, modulo 2^32.
REQ-012 SHALL have port: cout  output  1  carry out of bit 31.
REQ-013 SHALL have port: overflow  output  1  signed overflow; present only with ADDER_OVF_EN.

Function
REQ-014 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, both decoded from state.
REQ-016 SHALL, in IDLE with in_valid=1, latch a, b, cin at the edge, clear slice counter, clear partial result, enter BUSY.
REQ-017 SHALL, on each edge in BUSY, add slice k (bits k*SLICE_W+SLICE_W-1..k*SLICE_W) of a and b plus carry register, write sum slice into result, update carry register, increment k.
REQ-018 SHALL leave BUSY for DONE on the edge processing slice N-1; out_valid rises exactly N edges after the accepting edge (4 for SLICE_W=8).
REQ-019 SHALL use latched cin as carry into slice 0; cout SHALL equal carry out of slice N-1.
REQ-020 SHALL hold result, cout, overflow stable in DONE until out_valid and out_ready both 1 at an edge, then enter IDLE.
REQ-021 SHALL ignore in_valid, a, b, cin outside IDLE; input changes during BUSY SHALL not affect the result.
REQ-022 SHALL keep result, cout, overflow at last values in IDLE after handoff (not cleared until next acceptance).
REQ-023 SHALL not bypass: back-to-back transactions with in_valid=out_ready=1 complete one per N+2 cycles.
REQ-024 SHALL produce result identical to combinational (a + b + cin) mod 2^32 for all operands, including all-ones and all-zero cases.

Reset
REQ-025 SHALL, on rst_n=0, immediately and asynchronously force state IDLE, slice counter 0, carry register 0, result 0, cout 0, overflow 0.
REQ-026 SHALL present in_ready=1, out_valid=0 while rst_n=0.
REQ-027 SHALL abort any BUSY or DONE transaction on reset with no output; first edge after rst_n deassertion SHALL be able to accept operands.

Configuration
REQ-028 SHALL, with ADDER_OVF_EN defined, provide port overflow = (a[31] == b[31]) && (result[31] != a[31]) using latched operands, valid in DONE.
REQ-029 SHALL, without ADDER_OVF_EN, omit the overflow port and its logic; all other behaviour unchanged.

Verification
REQ-030 SHALL cover: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> out_valid 4 edges after accept, result=0x00000000, cout=1, overflow=0.
REQ-031 SHALL cover: a=0x7FFFFFFF, b=0x00000001, cin=0 -> result=0x80000000, cout=0, overflow=1 (ADDER_OVF_EN defined).
REQ-032 SHALL cover: a=0x12345678, b=0x0FEDCBA8, cin=1, out_ready=0 for 10 cycles, in_valid toggling with new operands -> result=0x22222221 held, cout=0, in_ready=0 throughout, stray operands ignored.
REQ-033 SHALL cover: rst_n pulsed low 2 edges into BUSY -> out_valid=0, result=0, in_ready=1 immediately; next transaction a=5, b=3, cin=0 -> result=8.
REQ-034 SHALL cover: in_valid and out_ready tied 1, 100 random operand sets -> one result per 6 cycles (SLICE_W=8), every result and cout match reference model.
REQ-035 SHALL cover: SLICE_W=1 and SLICE_W=32 builds with a=0x80000000, b=0x80000000, cin=1 -> result=0x00000001, cout=1, latency 32 and 1 edges respectively.

Source files
------------

// File: rtl/adder_32bit_seq.sv
// adder_32bit_seq: 32-bit adder that ripples through the operands one
// SLICE_W-bit slice per clock, with a valid/ready handshake on each side.
// SLICE_W (1, 2, 4, 8, 16 or 32) sets the slice width; a sum takes
// 32/SLICE_W cycles in BUSY.
// Optional feature: define ADDER_OVF_EN to add the signed 'overflow' output.
module adder_32bit_seq #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        cout
`ifdef ADDER_OVF_EN
  ,
  output logic        overflow
`endif
);

  localparam int         N      = 32 / SLICE_W;
  localparam logic [4:0] LAST_K = 5'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [4:0]          r_k;       // index of the slice handled on the next BUSY edge
  logic                r_carry;   // carry into slice r_k (starts as the latched cin)
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [31:0]         r_result;
  logic                r_cout;
`ifdef ADDER_OVF_EN
  logic                r_overflow;
  logic                w_overflow;
`endif

  logic [4:0]          w_base;
  logic [SLICE_W-1:0]  w_a_slice;
  logic [SLICE_W-1:0]  w_b_slice;
  logic [SLICE_W:0]    w_sum;

  // Slice k starts at bit k*SLICE_W; the product never exceeds 31.
  assign w_base    = 5'(r_k * SLICE_W);
  assign w_a_slice = r_a[w_base +: SLICE_W];
  assign w_b_slice = r_b[w_base +: SLICE_W];
  assign w_sum     = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE_W{1'b0}}, r_carry};

`ifdef ADDER_OVF_EN
  // On the last slice, the slice MSB is bit 31 of the final sum.
  assign w_overflow = (r_a[31] == r_b[31]) && (w_sum[SLICE_W-1] != r_a[31]);
`endif

  // Handshake FSM plus the slice datapath; all state is reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_k        <= 5'd0;
      r_carry    <= 1'b0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_result   <= 32'd0;
      r_cout     <= 1'b0;
`ifdef ADDER_OVF_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_k        <= 5'd0;
            r_result   <= 32'd0;
            r_cout     <= 1'b0;
`ifdef ADDER_OVF_EN
            r_overflow <= 1'b0;
`endif
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_result[w_base +: SLICE_W] <= w_sum[SLICE_W-1:0];
          r_carry                     <= w_sum[SLICE_W];
          if (r_k == LAST_K) begin
            r_k        <= 5'd0;
            r_cout     <= w_sum[SLICE_W];
`ifdef ADDER_OVF_EN
            r_overflow <= w_overflow;
`endif
            r_state    <= DONE;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
        DONE: begin
          // Result, cout and overflow stay frozen until the consumer takes them.
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign cout      = r_cout;
`ifdef ADDER_OVF_EN
  assign overflow  = r_overflow;
`endif

endmodule

// File: tb/tb_adder_32bit_seq.sv
// tb_adder_32bit_seq: directed bench for adder_32bit_seq. Main instance uses
// SLICE_W=8; two extra instances cover SLICE_W=1 and SLICE_W=32.
// Overflow checks are compiled in only when ADDER_OVF_EN is defined.
`ifdef ADDER_OVF_EN
`define OVF_ARG(v) , v
`else
`define OVF_ARG(v)
`endif

module tb_adder_32bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;

  logic        in_valid, out_ready, in_ready, out_valid, cout;
  logic [31:0] result;
  logic        in_valid1, out_ready1, in_ready1, out_valid1, cout1;
  logic [31:0] result1;
  logic        in_valid32, out_ready32, in_ready32, out_valid32, cout32;
  logic [31:0] result32;
`ifdef ADDER_OVF_EN
  logic        overflow, overflow1, overflow32;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure the transaction period.
  always @(posedge clk) cyc <= cyc + 1;

  adder_32bit_seq #(.SLICE_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout)
`ifdef ADDER_OVF_EN
    , .overflow(overflow)
`endif
  );

  adder_32bit_seq #(.SLICE_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .cout(cout1)
`ifdef ADDER_OVF_EN
    , .overflow(overflow1)
`endif
  );

  adder_32bit_seq #(.SLICE_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid32), .out_ready(out_ready32),
    .result(result32), .cout(cout32)
`ifdef ADDER_OVF_EN
    , .overflow(overflow32)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < budget) begin
      step();
      lat++;
    end
  endtask

  // One full transaction on the SLICE_W=8 instance with out_ready held high.
  task automatic run_txn(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic [31:0] er, input logic ec
`ifdef ADDER_OVF_EN
                         , input logic eo
`endif
                         );
    int lat;
    a = ta; b = tb; cin = tc; out_ready = 1'b1;
    chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
    wait_valid(40, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef ADDER_OVF_EN
    chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
`endif
    step();
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_result_held"}, result, er);
    chk({tag, "_cout_held"}, 32'(cout), 32'(ec));
  endtask

  // Abort the run if something stalls far beyond any legal latency.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int          lat;
    int          k;
    int          acc;
    int          prev;
    logic [32:0] exp_sum;

    rst_n = 1'b1; a = 32'd0; b = 32'd0; cin = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed vectors
    run_txn("ones_plus_one", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1 `OVF_ARG(1'b0));
    run_txn("pos_ovf",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0 `OVF_ARG(1'b1));
    run_txn("zeros",         32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0 `OVF_ARG(1'b0));
    run_txn("all_ones_cin",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1 `OVF_ARG(1'b0));
    run_txn("neg_ovf",       32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1 `OVF_ARG(1'b1));
    run_txn("cin_ripple",    32'h89AB_CDEF, 32'h7654_3210, 1'b1, 32'h0000_0000, 1'b1 `OVF_ARG(1'b0));

    // Backpressure with stray operands offered while busy/done
    a = 32'h1234_5678; b = 32'h0FED_CBA8; cin = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      in_valid = i[0];
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'(i >= 3));
      if (i >= 3) begin
        chk("bp_result", result, 32'h2222_2221);
        chk("bp_cout", 32'(cout), 32'd0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_result", result, 32'h2222_2221);

    // Reset two edges into BUSY
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    step();
    a = 32'd5; b = 32'd3; cin = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_accept", 32'(in_ready), 32'd0);
    wait_valid(40, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_result", result, 32'd8);
    step();

    // Back-to-back random transactions with both handshakes tied high
    out_ready = 1'b1; in_valid = 1'b1; prev = 0;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      k = 0;
      while (in_ready !== 1'b1 && k < 20) begin
        step();
        k++;
      end
      chk("b2b_ready", 32'(in_ready), 32'd1);
      exp_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      step();
      acc = cyc;
      if (i > 0) chk("b2b_period", 32'(acc - prev), 32'd6);
      prev = acc;
      wait_valid(20, lat);
      chk("b2b_latency", 32'(lat), 32'd4);
      chk("b2b_result", result, exp_sum[31:0]);
      chk("b2b_cout", 32'(cout), 32'(exp_sum[32]));
    end
    in_valid = 1'b0;
    step(); step();

    // SLICE_W=1 instance
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1; out_ready1 = 1'b1;
    chk("w1_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    chk("w1_latency", 32'(lat), 32'd32);
    chk("w1_result", result1, 32'h0000_0001);
    chk("w1_cout", 32'(cout1), 32'd1);
`ifdef ADDER_OVF_EN
    chk("w1_overflow", 32'(overflow1), 32'd1);
`endif
    step();
    chk("w1_handoff", 32'(out_valid1), 32'd0);

    // SLICE_W=32 instance
    out_ready32 = 1'b1;
    chk("w32_ready", 32'(in_ready32), 32'd1);
    in_valid32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    lat = 0;
    while (out_valid32 !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    chk("w32_latency", 32'(lat), 32'd1);
    chk("w32_result", result32, 32'h0000_0001);
    chk("w32_cout", 32'(cout32), 32'd1);
`ifdef ADDER_OVF_EN
    chk("w32_overflow", 32'(overflow32), 32'd1);
`endif
    step();
    chk("w32_handoff", 32'(out_valid32), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
